// File: rtl/memory_arbiter.sv
// Unified RAM port arbiter between instruction fetch and data access.
// Registered grant FSM with alternation, halt drain and wait-state timeout.
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    input  logic              halt,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              bus_err,
    output logic              drained
);

    localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              halt_seen_q, halt_seen_d;
    logic              dreq;

    assign dreq = dREN | dWEN;
    assign drained = halt_seen_q & (state_q == IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            wcnt_q      <= '0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            wcnt_q      <= wcnt_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        wcnt_d      = wcnt_q;
        halt_seen_d = halt_seen_q | halt;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = iREN;
        dwait       = dreq;
        iload       = '0;
        dload       = '0;
        bus_err     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Under contention the side not served last time goes next
                if (!halt_seen_q) begin
                    if (dreq && (!iREN || !last_d_q)) begin
                        state_d  = GRANT_D;
                        last_d_d = 1'b1;
                        wcnt_d   = '0;
                    end else if (iREN) begin
                        state_d  = GRANT_I;
                        last_d_d = 1'b0;
                        wcnt_d   = '0;
                    end
                end
            end
            GRANT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_ready) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    state_d = IDLE;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            GRANT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ram_ready) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = IDLE;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ERR: begin
                // Release the aborted owner with a zero load
                bus_err = 1'b1;
                if (last_d_q) dwait = 1'b0;
                else iwait = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic,
// all outputs compared each cycle against a transaction-level model.
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN, dREN, dWEN, halt, ram_ready;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dstore, ramload;
    logic          iwait, dwait, ramREN, ramWEN, bus_err, drained;
    logic [DW-1:0] iload, dload, ramstore;
    logic [AW-1:0] ramaddr;

    int tests = 0;
    int fails = 0;

    // Model: who owns the port (0 none, 1 fetch, 2 data, 3 abort report)
    int m_owner;
    bit m_prev_data;
    bit m_abort_data;
    int m_waited;
    bit m_halted;

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .halt(halt),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
        .bus_err(bus_err), .drained(drained)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_prev_data = 0;
        m_abort_data = 0;
        m_waited = 0;
        m_halted = 0;
    endtask

    task automatic check_all();
        bit dq;
        bit e_ren, e_wen, e_iw, e_dw, e_be, e_dr;
        logic [31:0] e_addr, e_st, e_il, e_dl;
        dq = dREN | dWEN;
        e_ren = 0; e_wen = 0; e_addr = 0; e_st = 0;
        e_iw = iREN; e_dw = dq; e_il = 0; e_dl = 0; e_be = 0;
        e_dr = m_halted && (m_owner == 0);
        if (m_owner == 1) begin
            e_ren = iREN;
            e_addr = iaddr;
            if (iREN && ram_ready) begin
                e_iw = 0;
                e_il = ramload;
            end
        end else if (m_owner == 2) begin
            e_addr = daddr;
            e_st = dstore;
            e_wen = dWEN;
            e_ren = dREN && !dWEN;
            if (dq && ram_ready) begin
                e_dw = 0;
                e_dl = ramload;
            end
        end else if (m_owner == 3) begin
            e_be = 1;
            if (m_abort_data) e_dw = 0;
            else e_iw = 0;
        end
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_st);
        chk("iwait", iwait, e_iw);
        chk("iload", iload, e_il);
        chk("dwait", dwait, e_dw);
        chk("dload", dload, e_dl);
        chk("bus_err", bus_err, e_be);
        chk("drained", drained, e_dr);
    endtask

    task automatic model_step();
        bit dq, req;
        bit was_halted;
        dq = dREN | dWEN;
        was_halted = m_halted;
        m_halted = m_halted | halt;
        if (m_owner == 0) begin
            if (!was_halted) begin
                if (dq && (!iREN || !m_prev_data)) begin
                    m_owner = 2;
                    m_prev_data = 1;
                    m_waited = 0;
                end else if (iREN) begin
                    m_owner = 1;
                    m_prev_data = 0;
                    m_waited = 0;
                end
            end
        end else if (m_owner == 3) begin
            m_owner = 0;
        end else begin
            req = (m_owner == 1) ? iREN : dq;
            if (!req || ram_ready) begin
                m_owner = 0;
            end else if (m_waited + 1 >= TO) begin
                m_abort_data = (m_owner == 2);
                m_owner = 3;
            end else begin
                m_waited++;
            end
        end
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    string seq;

    initial begin
        nRST = 0;
        iREN = 1; dREN = 0; dWEN = 0; halt = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h1111_2222;
        model_reset();
        #2;
        check_all();
        chk("rst_iwait", iwait, 1'b1);
        chk("rst_drained", drained, 1'b0);
        @(negedge CLK);
        nRST = 1;
        iREN = 0;

        // Reset while a write is on the bus
        dWEN = 1; daddr = 32'h10; dstore = 32'h55;
        settle();
        tick();
        settle();
        chk("t1_wen_before", ramWEN, 1'b1);
        nRST = 0;
        model_reset();
        #1;
        check_all();
        chk("t1_wen_in_rst", ramWEN, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1; dWEN = 0; ram_ready = 1;
        settle();
        chk("t1_no_cmpl", ramWEN, 1'b0);
        tick();

        // Instruction fetch with two wait states
        iREN = 1; iaddr = 32'h40; ram_ready = 0; ramload = 32'hDEADBEEF;
        settle();
        tick();
        for (int k = 0; k < 3; k++) begin
            ram_ready = (k == 2);
            settle();
            chk("t2_ren", ramREN, 1'b1);
            chk("t2_addr", ramaddr, 32'h40);
            chk("t2_iwait", iwait, (k == 2) ? 1'b0 : 1'b1);
            chk("t2_iload", iload, (k == 2) ? 32'hDEADBEEF : 32'h0);
            tick();
        end
        iREN = 0;
        settle();
        chk("t2_idle", ramREN, 1'b0);
        tick();

        // Contention: completions must alternate D,I,D,I
        iREN = 1; dREN = 1; ram_ready = 1; seq = "";
        iaddr = 32'h44; daddr = 32'h90; ramload = 32'h0BAD_F00D;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (dwait === 1'b0) seq = {seq, "D"};
            if (iwait === 1'b0) seq = {seq, "I"};
            tick();
        end
        chk("t3_count", seq.len(), 4);
        chk("t3_seq", (seq == "DIDI") ? 1 : 0, 1);
        iREN = 0; dREN = 0;
        settle();
        tick();

        // Read+write together: write takes the bus
        dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        settle();
        tick();
        settle();
        chk("t4_wen", ramWEN, 1'b1);
        chk("t4_ren", ramREN, 1'b0);
        chk("t4_store", ramstore, 32'h1234);
        chk("t4_addr", ramaddr, 32'h80);
        chk("t4_dwait", dwait, 1'b0);
        tick();
        dREN = 0; dWEN = 0;
        settle();
        tick();

        // Timeout abort on a fetch
        iREN = 1; iaddr = 32'h48; ram_ready = 0; ramload = 32'hAAAA5555;
        settle();
        tick();
        for (int k = 0; k < TO; k++) begin
            settle();
            chk("t5_ren", ramREN, 1'b1);
            chk("t5_noerr", bus_err, 1'b0);
            tick();
        end
        settle();
        chk("t5_err", bus_err, 1'b1);
        chk("t5_iwait", iwait, 1'b0);
        chk("t5_iload", iload, 32'h0);
        chk("t5_ren_err", ramREN, 1'b0);
        tick();
        iREN = 0;
        settle();
        chk("t5_err_gone", bus_err, 1'b0);
        tick();

        // Random traffic, every cycle scored against the model
        for (int k = 0; k < 600; k++) begin
            iREN = ($urandom_range(0, 3) != 0);
            dREN = $urandom_range(0, 1);
            dWEN = ($urandom_range(0, 2) == 0);
            ram_ready = ($urandom_range(0, 9) < 3);
            iaddr = $urandom;
            daddr = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            settle();
            tick();
        end

        // Halt arrives while a data access is in flight
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        settle();
        tick();
        settle();
        tick();
        dREN = 1; daddr = 32'hC0; ramload = 32'h7777_0000;
        settle();
        tick();
        iREN = 1; halt = 1;
        settle();
        chk("t6_ren", ramREN, 1'b1);
        chk("t6_iwait", iwait, 1'b1);
        tick();
        halt = 0; ram_ready = 1;
        settle();
        chk("t6_dwait", dwait, 1'b0);
        chk("t6_dload", dload, 32'h7777_0000);
        tick();
        dREN = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t6_drained", drained, 1'b1);
            chk("t6_iwait_hold", iwait, 1'b1);
            chk("t6_no_grant", ramREN, 1'b0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Arbitrates the single unified RAM port between instruction fetch (IF stage) and data access (MEM stage) of the pipelined processor. Registered FSM grants one requester at a time and drives the RAM strobes. It returns wait/load to the requesters so the hazard logic and latches stall correctly. It also enforces halt drain, anti-starvation and a wait-state timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 64, max RAM wait cycles per access before abort (>=2)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request (level, held until iwait=0)
iaddr  in  ADDR_W  instruction address
iwait  out  1  instruction stall; 0 only in completion cycle
iload  out  DATA_W  instruction word, valid when iwait=0
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  ADDR_W  data address
dstore  in  DATA_W  write data
dwait  out  1  data stall; 0 only in completion cycle
dload  out  DATA_W  read data, valid when dwait=0
halt  in  1  processor halt; blocks new grants
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ram_ready  in  1  RAM access completes this cycle
bus_err  out  1  one-cycle pulse on timeout abort
drained  out  1  halt seen and arbiter idle

Behaviour:
- Reset (nRST=0, async): state=IDLE, last_d=0, wcnt=0, halt_seen=0. All RAM strobes 0, ramaddr/ramstore 0. iwait=iREN, dwait=dREN|dWEN, bus_err=0, drained=0.
- States: IDLE, GRANT_I, GRANT_D, ERR.
- IDLE: no RAM strobes. Grant decision is registered; the earliest completion is the cycle after the request is first seen.
  - If halt_seen: no grant.
  - Else dreq=(dREN|dWEN) and (!iREN|!last_d) -> GRANT_D, last_d<=1.
  - Else iREN -> GRANT_I, last_d<=0.
  - Both requesting: data wins unless the previous grant was data, in which case instruction wins. This gives strict alternation under contention.
- GRANT_I: ramREN=1, ramaddr=iaddr.
  - ram_ready=1: iwait=0, iload=ramload (combinational), next IDLE.
- GRANT_D: ramaddr=daddr, ramstore=dstore. dWEN has priority: ramWEN=dWEN, ramREN=dREN&!dWEN.
  - ram_ready=1: dwait=0, dload=ramload, next IDLE.
- Non-completing cycles: iwait=iREN, dwait=dREN|dWEN. The load outputs are 0 when their wait is 1.
- Requester drops its request while granted (e.g. pipeline flush): strobes still follow the current inputs (0). Next state is IDLE with no completion and no error.
- wcnt: cleared on entry to any GRANT state, +1 each GRANT cycle without ram_ready. If wcnt reaches TIMEOUT-1 without ram_ready: next ERR.
- ERR: one cycle. bus_err=1, the owner's wait=0, owner's load=0, no RAM strobes. Next IDLE.
- halt: halt_seen<=1 on any cycle with halt=1, sticky until reset. An in-flight grant finishes normally. drained=halt_seen & state==IDLE.
- Only one of ramREN/ramWEN is high in any cycle. Both are 0 outside GRANT states.

Test Plan:
1. Reset mid-GRANT_D with ramWEN=1: nRST low -> same-cycle ramWEN=0, state IDLE. No completion after release until a new request.
2. iREN only, iaddr=0x40, ram_ready on 3rd grant cycle, ramload=0xDEADBEEF -> ramREN=1 with ramaddr=0x40 for 3 cycles. iwait=0 and iload=0xDEADBEEF in the 3rd. IDLE next.
3. iREN and dREN both held continuously, ram_ready=1 always -> grants alternate D,I,D,I. First grant is D (last_d=0 after reset).
4. dWEN=1 and dREN=1 with daddr=0x80, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234. dwait=0 on ram_ready.
5. TIMEOUT=4, ram_ready held 0 during GRANT_I -> 4 grant cycles, then ERR with bus_err=1 for one cycle, iwait=0, iload=0. Then IDLE.
6. halt=1 during GRANT_D with iREN pending -> data completes. No instruction grant follows, drained=1 from the next IDLE cycle, iwait stays 1.
